jt89_dac_out: RTL and testbench

//  Output stage fed by the PSG mixer's signed 12-bit 'sound' bus.
//  - Applies a programmable power-of-two gain with saturation and a sticky clip flag.
//  - Re-registers the result as a valid-qualified sample.
//  - Drives a first-order sigma-delta 1-bit DAC for an FPGA pin + RC filter.

---
 rtl/jt89_dac_out_pkg.sv | 14 +
 rtl/jt89_sdm.sv | 34 +++
 rtl/jt89_dac_out.sv | 156 +++++++++++++++
 tb/tb_jt89_dac_out.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/jt89_dac_out_pkg.sv
// Shared constants and helpers for the jt89 output stage: sample width,
// gain width, saturation limits and signed-to-offset-binary conversion.
package jt89_dac_out_pkg;

    localparam int SND_W  = 12;
    localparam int GAIN_W = 3;
    localparam int SMAX   = (2 ** (SND_W - 1)) - 1;
    localparam int SMIN   = -(2 ** (SND_W - 1));

    function automatic logic [SND_W-1:0] to_offset_bin(input logic signed [SND_W-1:0] s);
        return {~s[SND_W-1], s[SND_W-2:0]};
    endfunction

endpackage

// File: rtl/jt89_sdm.sv
// First-order sigma-delta modulator: accumulates an offset-binary sample every
// clock and emits the carry as a 1-bit stream for an external RC filter.
module jt89_sdm #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic          dout
);

    logic [DW:0] acc_q, acc_d;
    logic        dout_q, dout_d;

    // NOTE: every variable assigned in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        acc_d  = {1'b0, acc_q[DW-1:0]} + {1'b0, din};
        dout_d = acc_d[DW];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/jt89_dac_out.sv
// PSG output stage: power-of-two gain with saturation and sticky clip flag,
// valid-qualified sample output and sigma-delta DAC. Define JT89_DAC_DCBLOCK_EN
// to insert a DC-blocking stage ahead of the gain (adds one cycle of latency).
module jt89_dac_out
    import jt89_dac_out_pkg::*;
#(
    parameter int DW        = SND_W,
    parameter int DCB_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_en,
    input  logic signed [DW-1:0] sound,
    input  logic [GAIN_W-1:0]    gain,
    input  logic                 clip_clr,
    output logic signed [DW-1:0] snd_out,
    output logic                 snd_valid,
    output logic                 clip,
    output logic                 dac_bit
);

    localparam int PW = DW + 7;
    localparam logic signed [PW-1:0] P_MAX = PW'(SMAX);
    localparam logic signed [PW-1:0] P_MIN = PW'(SMIN);

    // S1: capture sample and gain on the strobe
    logic signed [DW-1:0] x1_q, x1_d;
    logic [GAIN_W-1:0]    g1_q, g1_d;
    logic                 v1_q, v1_d;

    always_comb begin
        x1_d = x1_q;
        g1_d = g1_q;
        v1_d = 1'b0;
        if (sample_en) begin
            x1_d = sound;
            g1_d = gain;
            v1_d = 1'b1;
        end
    end

    // S2 operands, either straight from S1 or from the DC blocker
    logic signed [DW-1:0] x2;
    logic [GAIN_W-1:0]    g2;
    logic                 v2;

`ifdef JT89_DAC_DCBLOCK_EN
    localparam int YW = DW + DCB_SHIFT;
    localparam int YX = YW + 2;
    localparam logic signed [YX-1:0] Y_MAX = YX'((1 <<< (YW - 1)) - 1);
    localparam logic signed [YX-1:0] Y_MIN = YX'(-(1 <<< (YW - 1)));

    logic signed [DW-1:0] xp_q, xp_d;
    logic signed [YW-1:0] y_q, y_d;
    logic [GAIN_W-1:0]    gb_q, gb_d;
    logic                 vb_q, vb_d;
    logic signed [YX-1:0] y_wide;

    // y carries DCB_SHIFT fractional bits; clamping y keeps its integer part within DW bits
    always_comb begin
        y_wide = ((YX'(x1_q) - YX'(xp_q)) <<< DCB_SHIFT) + YX'(y_q) - YX'(y_q >>> DCB_SHIFT);
        xp_d   = xp_q;
        y_d    = y_q;
        gb_d   = gb_q;
        vb_d   = 1'b0;
        if (v1_q) begin
            xp_d = x1_q;
            gb_d = g1_q;
            vb_d = 1'b1;
            if (y_wide > Y_MAX)      y_d = Y_MAX[YW-1:0];
            else if (y_wide < Y_MIN) y_d = Y_MIN[YW-1:0];
            else                     y_d = y_wide[YW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xp_q <= '0;
            y_q  <= '0;
            gb_q <= '0;
            vb_q <= 1'b0;
        end else begin
            xp_q <= xp_d;
            y_q  <= y_d;
            gb_q <= gb_d;
            vb_q <= vb_d;
        end
    end

    assign x2 = y_q[YW-1:DCB_SHIFT];
    assign g2 = gb_q;
    assign v2 = vb_q;
`else
    assign x2 = x1_q;
    assign g2 = g1_q;
    assign v2 = v1_q;
`endif

    // S2: gain, saturation and sticky clip (a new saturation beats a clear)
    logic signed [PW-1:0] prod;
    logic signed [DW-1:0] snd_out_q, snd_out_d;
    logic                 snd_valid_q, snd_valid_d;
    logic                 clip_q, clip_d;

    always_comb begin
        prod        = PW'(x2) <<< g2;
        snd_out_d   = snd_out_q;
        snd_valid_d = 1'b0;
        clip_d      = clip_q & ~clip_clr;
        if (v2) begin
            snd_valid_d = 1'b1;
            if (prod > P_MAX) begin
                snd_out_d = P_MAX[DW-1:0];
                clip_d    = 1'b1;
            end else if (prod < P_MIN) begin
                snd_out_d = P_MIN[DW-1:0];
                clip_d    = 1'b1;
            end else begin
                snd_out_d = prod[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x1_q        <= '0;
            g1_q        <= '0;
            v1_q        <= 1'b0;
            snd_out_q   <= '0;
            snd_valid_q <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            x1_q        <= x1_d;
            g1_q        <= g1_d;
            v1_q        <= v1_d;
            snd_out_q   <= snd_out_d;
            snd_valid_q <= snd_valid_d;
            clip_q      <= clip_d;
        end
    end

    logic [DW-1:0] sdm_din;
    assign sdm_din = to_offset_bin(snd_out_q);

    jt89_sdm #(.DW(DW)) u_sdm (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sdm_din),
        .dout  (dac_bit)
    );

    assign snd_out   = snd_out_q;
    assign snd_valid = snd_valid_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_jt89_dac_out.sv
// Directed bench for jt89_dac_out: latency, gain, saturation/clip, SDM density
// and mid-flight reset; DC-blocker behaviour when JT89_DAC_DCBLOCK_EN is defined.
module tb_jt89_dac_out;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_en = 1'b0;
    logic signed [11:0] sound = '0;
    logic [2:0]        gain = '0;
    logic              clip_clr = 1'b0;
    logic signed [11:0] snd_out;
    logic              snd_valid;
    logic              clip;
    logic              dac_bit;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jt89_dac_out dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .sound     (sound),
        .gain      (gain),
        .clip_clr  (clip_clr),
        .snd_out   (snd_out),
        .snd_valid (snd_valid),
        .clip      (clip),
        .dac_bit   (dac_bit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // strobe one sample, return two edges later when it should be on snd_out
    task automatic sample(input int s, input int g);
        sample_en = 1'b1;
        sound     = 12'(s);
        gain      = 3'(g);
        tick();
        sample_en = 1'b0;
        tick();
    endtask

    task automatic count_ones(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) tick();
        for (int i = 0; i < 4096; i++) begin
            tick();
            n += int'(dac_bit);
        end
    endtask

    task automatic pulse_clr();
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
    endtask

    int ones;

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_snd_out", int'(snd_out), 0);
        check("rst_valid", int'(snd_valid), 0);
        check("rst_clip", int'(clip), 0);
        check("rst_dac_bit", int'(dac_bit), 0);
        rst_n = 1'b1;
        tick();

`ifndef JT89_DAC_DCBLOCK_EN
        // 1: latency and pass-through at unity gain
        sample_en = 1'b1; sound = 12'sd100; gain = 3'd0;
        tick();
        sample_en = 1'b0;
        check("t1_valid_n1", int'(snd_valid), 0);
        tick();
        check("t1_out_n2", int'(snd_out), 100);
        check("t1_valid_n2", int'(snd_valid), 1);
        check("t1_clip", int'(clip), 0);
        tick();
        check("t1_valid_n3", int'(snd_valid), 0);
        check("t1_hold", int'(snd_out), 100);

        // gain change without a strobe must not alter the output
        gain = 3'd7;
        tick();
        tick();
        check("gain_latch_hold", int'(snd_out), 100);
        check("gain_latch_valid", int'(snd_valid), 0);

        sample(-5, 2);
        check("neg_gain2", int'(snd_out), -20);
        sample(1000, 1);
        check("gain1_2000", int'(snd_out), 2000);
        check("gain1_noclip", int'(clip), 0);

        // 2: positive saturation, clear, clear colliding with a new saturation
        sample(300, 3);
        check("t2_sat_pos", int'(snd_out), 2047);
        check("t2_clip_set", int'(clip), 1);
        pulse_clr();
        check("t2_clip_clr", int'(clip), 0);
        sample_en = 1'b1; sound = 12'sd300; gain = 3'd3;
        tick();
        sample_en = 1'b0;
        clip_clr  = 1'b1;
        tick();
        clip_clr  = 1'b0;
        check("t2_set_wins", int'(clip), 1);
        check("t2_set_wins_out", int'(snd_out), 2047);
        pulse_clr();

        // 3: negative saturation and the exact-minimum edge case
        sample(-300, 3);
        check("t3_sat_neg", int'(snd_out), -2048);
        check("t3_clip_set", int'(clip), 1);
        pulse_clr();
        sample(-256, 3);
        check("t3_exact_min", int'(snd_out), -2048);
        check("t3_exact_noclip", int'(clip), 0);

        // 4: sigma-delta ones density over 4096 clocks
        sample(0, 0);
        count_ones(ones);
        check_rng("t4_mid_density", ones, 2047, 2049);
        sample(2047, 0);
        count_ones(ones);
        check_rng("t4_max_density", ones, 4094, 4096);
        sample(-2048, 0);
        count_ones(ones);
        check("t4_min_density", ones, 0);

        // 5: back-to-back strobes
        sample_en = 1'b1; sound = 12'sd1; gain = 3'd0;
        tick();
        sound = 12'sd2;
        tick();
        check("t5_out1", int'(snd_out), 1);
        check("t5_valid1", int'(snd_valid), 1);
        sound = 12'sd3;
        tick();
        check("t5_out2", int'(snd_out), 2);
        check("t5_valid2", int'(snd_valid), 1);
        sample_en = 1'b0;
        tick();
        check("t5_out3", int'(snd_out), 3);
        check("t5_valid3", int'(snd_valid), 1);
        tick();
        check("t5_valid_end", int'(snd_valid), 0);

        // 5b: reset while a sample is in flight
        sample(300, 3);
        for (int i = 0; i < 8; i++) tick();
        check("t5b_pre_clip", int'(clip), 1);
        sample_en = 1'b1; sound = 12'sd7;
        tick();
        sample_en = 1'b0;
        rst_n     = 1'b0;
        tick();
        check("t5b_rst_out", int'(snd_out), 0);
        check("t5b_rst_valid", int'(snd_valid), 0);
        check("t5b_rst_clip", int'(clip), 0);
        check("t5b_rst_dac", int'(dac_bit), 0);
        rst_n = 1'b1;
        tick();
        check("t5b_flush_valid1", int'(snd_valid), 0);
        tick();
        check("t5b_flush_valid2", int'(snd_valid), 0);
        check("t5b_flush_out", int'(snd_out), 0);
`else
        // 6: DC blocker with a constant input, one sample per clock
        sample_en = 1'b1; sound = 12'sd500; gain = 3'd0;
        tick();
        check("t6_valid_n1", int'(snd_valid), 0);
        tick();
        check("t6_valid_n2", int'(snd_valid), 0);
        tick();
        check("t6_valid_n3", int'(snd_valid), 1);
        check("t6_first", int'(snd_out), 500);
        tick();
        check("t6_second", int'(snd_out), 498);
        for (int i = 0; i < 255; i++) tick();
        check_rng("t6_one_tau", int'(snd_out), 150, 220);
        for (int i = 0; i < 2300; i++) tick();
        check_rng("t6_settled", int'(snd_out), 0, 2);
        check("t6_noclip", int'(clip), 0);
        sample_en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
